// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, saturation limits, stage-2 payload type and a
// signed clamp helper for the pid_steer datapath.
package pid_pkg;

  localparam int ERR_W     = 16;  // raw steering error width
  localparam int ERR_SAT_W = 10;  // saturated error width
  localparam int TERM_W    = 14;  // P/I/D term and PID sum width
  localparam int SPD_W     = 12;  // motor command width
  localparam int D_SAT_W   = 7;   // derivative difference width
  localparam int INTEG_W   = 16;  // integrator width
  localparam int FWD_W     = 11;  // base forward speed width

  localparam int ERR_SAT_MAX = (1 <<< (ERR_SAT_W - 1)) - 1;
  localparam int ERR_SAT_MIN = -(1 <<< (ERR_SAT_W - 1));
  localparam int D_SAT_MAX   = (1 <<< (D_SAT_W - 1)) - 1;
  localparam int D_SAT_MIN   = -(1 <<< (D_SAT_W - 1));
  localparam int SPD_MAX     = (1 <<< (SPD_W - 1)) - 1;
  localparam int SPD_MIN     = -(1 <<< (SPD_W - 1));

  // Registered stage-2 payload: the three terms travel with their valid
  // flag and the go bit sampled alongside the error.
  typedef struct packed {
    logic                     vld;
    logic                     go;
    logic signed [TERM_W-1:0] p_term;
    logic signed [TERM_W-1:0] i_term;
    logic signed [TERM_W-1:0] d_term;
  } s2_t;

  // Signed clamp of v into [lo, hi].
  function automatic int sat_int(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_steer_dqueue.sv
// pid_dqueue: DEPTH-entry shift register of past saturated errors.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of every entry (wins over en)
//   en         : shift din in at the head
//   din        : sample to shift in
//   oldest     : current tail entry, i.e. the value shifted out by the
//                next enabled shift
module pid_dqueue #(
  parameter int DEPTH = 2,
  parameter int W     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] oldest
);

  // tap[0] is the incoming sample, tap[k] the output of entry k-1.
  logic signed [W-1:0] tap [DEPTH+1];

  assign tap[0] = din;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic signed [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_reg <= '0;
      end else if (clr) begin
        q_reg <= '0;
      end else if (en) begin
        q_reg <= tap[gi];
      end
    end

    assign tap[gi+1] = q_reg;
  end

  assign oldest = tap[DEPTH];

endmodule

// File: rtl/pid_steer.sv
// pid_steer: 3-stage pipelined PID turning a steering error into signed
// left/right motor speed commands.
//   clk, rst_n          : clock, asynchronous active-low reset
//   error, err_vld      : signed error and its one-cycle qualifier
//   go                  : enable; low clears I/D history and zeroes speeds
//   frwrd_spd           : unsigned base forward speed
//   lft_spd, rght_spd   : signed saturated motor commands (held between updates)
//   pid_vld             : one-cycle strobe marking a new speed pair
module pid_steer
  import pid_pkg::*;
#(
  parameter logic [3:0] P_COEFF = 4'd3,
  parameter logic [3:0] D_COEFF = 4'd6,
  parameter int         I_SHIFT = 4,
  parameter int         D_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] error,
  input  logic                    err_vld,
  input  logic                    go,
  input  logic [FWD_W-1:0]        frwrd_spd,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd,
  output logic                    pid_vld
);

  // ---------------- stage 1: saturate, history, integrate ----------------
  logic signed [ERR_SAT_W-1:0] err_sat_next;
  logic signed [ERR_SAT_W-1:0] err_sat_reg;
  logic signed [ERR_SAT_W-1:0] oldest;
  logic signed [ERR_SAT_W-1:0] oldest_reg;
  logic signed [INTEG_W-1:0]   err_ext;
  logic signed [INTEG_W-1:0]   integ_sum;
  logic signed [INTEG_W-1:0]   integ_reg;
  logic                        integ_ovf;
  logic                        vld1_reg;
  logic                        go1_reg;

  always_comb begin
    err_sat_next = ERR_SAT_W'(sat_int(int'(error), ERR_SAT_MIN, ERR_SAT_MAX));
    err_ext      = INTEG_W'(err_sat_next);
    integ_sum    = integ_reg + err_ext;
    // Overflow only when both operands share a sign the sum does not.
    integ_ovf    = (integ_reg[INTEG_W-1] == err_ext[INTEG_W-1]) &&
                   (integ_sum[INTEG_W-1] != integ_reg[INTEG_W-1]);
  end

  pid_dqueue #(
    .DEPTH (D_DEPTH),
    .W     (ERR_SAT_W)
  ) u_dqueue (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!go),
    .en     (err_vld),
    .din    (err_sat_next),
    .oldest (oldest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_reg    <= 1'b0;
      go1_reg     <= 1'b0;
      err_sat_reg <= '0;
      oldest_reg  <= '0;
      integ_reg   <= '0;
    end else begin
      vld1_reg <= err_vld;
      if (err_vld) begin
        go1_reg     <= go;
        err_sat_reg <= err_sat_next;
        oldest_reg  <= oldest;
      end
      // Clearing on go=0 takes priority over accumulating a sample.
      if (!go) begin
        integ_reg <= '0;
      end else if (err_vld && !integ_ovf) begin
        integ_reg <= integ_sum;
      end
    end
  end

  // ---------------- stage 2: P, I and D terms ----------------
  s2_t s2_next;
  s2_t s2_reg;
  int  d_diff;

  always_comb begin
    d_diff         = sat_int(int'(err_sat_reg) - int'(oldest_reg), D_SAT_MIN, D_SAT_MAX);
    s2_next.vld    = vld1_reg;
    s2_next.go     = go1_reg;
    s2_next.p_term = TERM_W'(int'(err_sat_reg) * int'(P_COEFF));
    s2_next.i_term = TERM_W'(integ_reg >>> I_SHIFT);
    s2_next.d_term = TERM_W'(d_diff * int'(D_COEFF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_reg <= '0;
    end else if (vld1_reg) begin
      s2_reg <= s2_next;
    end else begin
      s2_reg.vld <= 1'b0;
    end
  end

  // ---------------- stage 3: sum, scale, mix into motor speeds ----------------
  logic signed [TERM_W-1:0] pid_sum;
  logic signed [TERM_W-1:0] corr;
  int                       lft_int;
  int                       rght_int;

  always_comb begin
    pid_sum  = s2_reg.p_term + s2_reg.i_term + s2_reg.d_term;
    corr     = pid_sum >>> 3;
    lft_int  = sat_int(int'(frwrd_spd) + int'(corr), SPD_MIN, SPD_MAX);
    rght_int = sat_int(int'(frwrd_spd) - int'(corr), SPD_MIN, SPD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_vld  <= 1'b0;
      lft_spd  <= '0;
      rght_spd <= '0;
    end else begin
      pid_vld <= s2_reg.vld;
      if (s2_reg.vld) begin
        lft_spd  <= s2_reg.go ? SPD_W'(lft_int)  : '0;
        rght_spd <= s2_reg.go ? SPD_W'(rght_int) : '0;
      end
    end
  end

endmodule

// File: tb/tb_pid_steer.sv
// tb_pid_steer: table-driven vectors, hand-written corner sequences and a
// randomized run, all checked against a plain-arithmetic reference model.
module tb_pid_steer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] error = '0;
  logic               err_vld = 1'b0;
  logic               go = 1'b0;
  logic [10:0]        frwrd_spd = '0;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               pid_vld;

  always #5 clk = ~clk;

  pid_steer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .error     (error),
    .err_vld   (err_vld),
    .go        (go),
    .frwrd_spd (frwrd_spd),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .pid_vld   (pid_vld)
  );

  typedef struct { int cyc; int lft; int rght; } exp_t;
  typedef struct { int lft; int rght; } obs_t;
  typedef struct { int err; int f; int lft; int rght; } vec_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state: integrator value and last two saturated errors.
  int   m_integ;
  int   m_hist[$];

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_integ = 0;
    m_hist.delete();
    repeat (2) m_hist.push_back(0);
  endtask

  // Applies one clock's worth of inputs to the model; called just before
  // the edge that samples them.
  task automatic model(input logic g, input logic v, input int e);
    int   es, old, nsum, p, i, dd, d, pid, corr, f;
    exp_t x;
    f = int'(frwrd_spd);
    if (!g) begin
      model_reset();
      if (v) begin
        x.cyc = cyc + 3; x.lft = 0; x.rght = 0;
        exp_q.push_back(x);
      end
    end else if (v) begin
      es  = clamp(e, -512, 511);
      old = m_hist.pop_front();
      m_hist.push_back(es);
      nsum = m_integ + es;
      if (nsum >= -32768 && nsum <= 32767) m_integ = nsum;
      p    = es * 3;
      i    = m_integ >>> 4;
      dd   = clamp(es - old, -64, 63);
      d    = dd * 6;
      pid  = p + i + d;
      corr = pid >>> 3;
      x.cyc  = cyc + 3;
      x.lft  = clamp(f + corr, -2048, 2047);
      x.rght = clamp(f - corr, -2048, 2047);
      exp_q.push_back(x);
    end
  endtask

  task automatic step(input logic g, input logic v, input int e);
    @(negedge clk);
    go      = g;
    err_vld = v;
    error   = 16'(e);
    model(g, v, e);
  endtask

  task automatic drain(input int n);
    repeat (n) step(go, 1'b0, 0);
  endtask

  task automatic set_spd(input int f);
    @(negedge clk);
    frwrd_spd = 11'(f);
    err_vld   = 1'b0;
    model(go, 1'b0, 0);
  endtask

  task automatic expect_obs(input string name, input int idx, input int l, input int r);
    if (idx < obs_q.size()) begin
      check({name, "_lft"}, obs_q[idx].lft, l);
      check({name, "_rght"}, obs_q[idx].rght, r);
    end else begin
      check({name, "_count"}, obs_q.size(), idx + 1);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pid_vld must line up with a model prediction, in order.
  always @(negedge clk) begin
    exp_t e;
    obs_t o;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("pid_vld_latency", int'(pid_vld), 1);
      if (pid_vld) begin
        check("lft_spd", int'(lft_spd), e.lft);
        check("rght_spd", int'(rght_spd), e.rght);
        o.lft = int'(lft_spd); o.rght = int'(rght_spd);
        obs_q.push_back(o);
      end
    end else if (pid_vld) begin
      check("pid_vld_spurious", int'(pid_vld), 0);
    end
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = '{err: 100,    f: 512,  lft: 597,  rght: 427};
    tbl[1] = '{err: 32767,  f: 512,  lft: 754,  rght: 270};
    tbl[2] = '{err: -32768, f: 512,  lft: 268,  rght: 756};
    tbl[3] = '{err: -5,     f: 0,    lft: -6,   rght: 6};
    tbl[4] = '{err: 20,     f: 2047, lft: 2047, rght: 2025};
    tbl[5] = '{err: 0,      f: 1000, lft: 1000, rght: 1000};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_lft", int'(lft_spd), 0);
    check("reset_rght", int'(rght_spd), 0);
    check("reset_pid_vld", int'(pid_vld), 0);
    rst_n = 1'b1;

    // Single samples from a cleared state.
    for (int k = 0; k < 6; k++) begin
      set_spd(tbl[k].f);
      obs_q.delete();
      step(1'b0, 1'b0, 0);
      step(1'b1, 1'b1, tbl[k].err);
      drain(5);
      expect_obs($sformatf("vec%0d", k), 0, tbl[k].lft, tbl[k].rght);
    end

    // Reset with a sample in flight.
    set_spd(512);
    obs_q.delete();
    step(1'b1, 1'b1, 100);
    step(1'b1, 1'b0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("midreset_lft", int'(lft_spd), 0);
    check("midreset_rght", int'(rght_spd), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain(5);
    check("midreset_no_vld", obs_q.size(), 0);
    step(1'b1, 1'b1, 100);
    drain(5);
    expect_obs("post_reset", 0, 597, 427);

    // Integrator overflow hold, then speed clamp.
    set_spd(0);
    obs_q.delete();
    step(1'b0, 1'b0, 0);
    for (int k = 0; k < 70; k++) step(1'b1, 1'b1, 511);
    drain(6);
    expect_obs("integ_64", 63, 447, -447);
    expect_obs("integ_65", 64, 447, -447);
    expect_obs("integ_70", 69, 447, -447);
    set_spd(2047);
    obs_q.delete();
    step(1'b1, 1'b1, 511);
    drain(6);
    expect_obs("spd_clamp", 0, 2047, 1600);

    // D queue depth.
    set_spd(0);
    obs_q.delete();
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 10);
    step(1'b1, 1'b1, 20);
    step(1'b1, 1'b1, 30);
    drain(6);
    expect_obs("dq_1", 0, 11, -11);
    expect_obs("dq_2", 1, 22, -22);
    expect_obs("dq_3", 2, 26, -26);

    // go dropped for one sample.
    set_spd(512);
    obs_q.delete();
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 100);
    step(1'b0, 1'b1, 100);
    step(1'b1, 1'b1, 100);
    drain(6);
    expect_obs("go_a", 0, 597, 427);
    expect_obs("go_low", 1, 0, 0);
    expect_obs("go_after", 2, 597, 427);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int   e;
      int   r;
      logic g;
      logic v;
      if (k % 100 == 0) begin
        drain(6);
        set_spd(int'($urandom_range(0, 2047)));
      end
      g = ($urandom_range(0, 9) != 0);
      v = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 3));
      case (r)
        0:       e = int'($urandom_range(0, 1023)) - 512;
        1:       e = int'($urandom_range(0, 65535)) - 32768;
        2:       e = 32767;
        default: e = -32768;
      endcase
      step(g, v, e);
    end
    drain(6);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
